// File: rtl/mcpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, state
// encodings, ALU operation codes, mux select values and the control word.
package mcpu_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // FSM states; encodings 13-15 are unused and recover to IF
    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_WBM  = 4'd4,
        S_MWR  = 4'd5,
        S_EX_R = 4'd6,
        S_WBR  = 4'd7,
        S_EX_I = 4'd8,
        S_WBI  = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11,
        S_ILL  = 4'd12
    } state_t;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    // Register destination select
    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    // Register file write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Full control word driven toward the datapath
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Combinational control-word decode: maps (state, opcode, memory ready) to
// every datapath enable and mux select. Anything not set stays 0.
module mcpu_ctrl_decode
    import mcpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] ir_op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Moore-style output decode, with mem_ready qualifying only the CEs
    // that must not fire until a memory access has actually completed.
    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_ID: begin
                // Precompute the branch target into ALUOut
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.ext_op    = 1'b1;
            end
            S_MADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
            end
            S_MRD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mdr_write = mem_ready;
            end
            S_WBM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EX_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_WBR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_EX_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                // Logical immediates are zero-extended, arithmetic ones signed
                case (ir_op)
                    OP_ANDI: begin ctrl.ext_op = 1'b0; ctrl.alu_op = ALU_AND; end
                    OP_ORI:  begin ctrl.ext_op = 1'b0; ctrl.alu_op = ALU_OR;  end
                    OP_SLTI: begin ctrl.ext_op = 1'b1; ctrl.alu_op = ALU_SLT; end
                    default: begin ctrl.ext_op = 1'b1; ctrl.alu_op = ALU_ADD; end
                endcase
            end
            S_WBI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_BR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.branch_ne     = (ir_op == OP_BNE);
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                // PC already holds PC+4 from fetch, so it is the link value
                if (ir_op == OP_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RA;
                    ctrl.mem_to_reg = M2R_PC;
                end
            end
            S_ILL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control unit: state register, next-state sequencing and
// reset gating of the strobes; output decode lives in mcpu_ctrl_decode.
module mcpu_ctrl_fsm
    import mcpu_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] ir_op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   ready;

    assign ready = USE_MEM_READY ? mem_ready : 1'b1;

    mcpu_ctrl_decode u_decode (
        .state     (state_q),
        .ir_op     (ir_op),
        .mem_ready (ready),
        .ctrl      (ctrl)
    );

    // State register; reset drops straight back to fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IF;
        else      state_q <= state_d;
    end

    // Next-state sequencing; memory states hold until the access completes
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = ready ? S_ID : S_IF;
            S_ID: begin
                case (ir_op)
                    OP_RTYPE:                           state_d = S_EX_R;
                    OP_LW, OP_SW:                       state_d = S_MADR;
                    OP_BEQ, OP_BNE:                     state_d = S_BR;
                    OP_J, OP_JAL:                       state_d = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_EX_I;
                    default:                            state_d = S_ILL;
                endcase
            end
            S_MADR: state_d = (ir_op == OP_SW) ? S_MWR : S_MRD;
            S_MRD:  state_d = ready ? S_WBM : S_MRD;
            S_MWR:  state_d = ready ? S_IF : S_MWR;
            S_EX_R: state_d = S_WBR;
            S_EX_I: state_d = S_WBI;
            default: state_d = S_IF;
        endcase
    end

    // Output drive; during reset every enable and strobe is held low while
    // the selects show their fetch values (state is already IF).
    always_comb begin
        pc_write      = ctrl.pc_write      & rst;
        pc_write_cond = ctrl.pc_write_cond & rst;
        mem_read      = ctrl.mem_read      & rst;
        mem_write     = ctrl.mem_write     & rst;
        ir_write      = ctrl.ir_write      & rst;
        mdr_write     = ctrl.mdr_write     & rst;
        reg_write     = ctrl.reg_write     & rst;
        illegal_op    = ctrl.illegal_op    & rst;
        branch_ne     = ctrl.branch_ne;
        iord          = ctrl.iord;
        reg_dst       = ctrl.reg_dst;
        mem_to_reg    = ctrl.mem_to_reg;
        alu_src_a     = ctrl.alu_src_a;
        alu_src_b     = ctrl.alu_src_b;
        ext_op        = ctrl.ext_op;
        alu_op        = ctrl.alu_op;
        pc_source     = ctrl.pc_source;
        state         = state_q;
    end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed bench for mcpu_ctrl_fsm: walks instruction classes, stalls and
// a mid-access reset, checking outputs 1 ns after each rising edge.
module tb_mcpu_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] ir_op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mdr_write, reg_write, alu_src_a, ext_op, illegal_op;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    mcpu_ctrl_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .ir_op         (ir_op),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .ext_op        (ext_op),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        ir_op     = 6'b100011;
        mem_ready = 1'b1;
        #12;
        // Reset: IF selects, strobes forced low
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_mem_read", 8'(mem_read), 8'd0);
        chk("rst_pc_write", 8'(pc_write), 8'd0);
        chk("rst_ir_write", 8'(ir_write), 8'd0);
        chk("rst_alu_src_b", 8'(alu_src_b), 8'd1);
        rst = 1'b1;
        #1;
        chk("if_mem_read", 8'(mem_read), 8'd1);
        chk("if_ir_write", 8'(ir_write), 8'd1);

        // lw: 0,1,2,3,4,0
        tick(); chk("lw_id_state", 8'(state), 8'd1);
        chk("lw_id_srcb", 8'(alu_src_b), 8'd3);
        chk("lw_id_ext", 8'(ext_op), 8'd1);
        tick(); chk("lw_madr_state", 8'(state), 8'd2);
        chk("lw_madr_srca", 8'(alu_src_a), 8'd1);
        chk("lw_madr_srcb", 8'(alu_src_b), 8'd2);
        tick(); chk("lw_mrd_state", 8'(state), 8'd3);
        chk("lw_mrd_mdr", 8'(mdr_write), 8'd1);
        chk("lw_mrd_iord", 8'(iord), 8'd1);
        tick(); chk("lw_wbm_state", 8'(state), 8'd4);
        chk("lw_wbm_regw", 8'(reg_write), 8'd1);
        chk("lw_wbm_m2r", 8'(mem_to_reg), 8'd1);
        tick(); chk("lw_done_state", 8'(state), 8'd0);

        // IF stall: 3 wait cycles then ready
        mem_ready = 1'b0;
        ir_op     = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_state", 8'(state), 8'd0);
            chk("stall_pcw", 8'(pc_write), 8'd0);
            chk("stall_irw", 8'(ir_write), 8'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_rel_state", 8'(state), 8'd0);
        chk("stall_rel_pcw", 8'(pc_write), 8'd1);
        chk("stall_rel_irw", 8'(ir_write), 8'd1);
        tick(); chk("stall_id_state", 8'(state), 8'd1);

        // beq
        tick(); chk("beq_state", 8'(state), 8'd10);
        chk("beq_pwc", 8'(pc_write_cond), 8'd1);
        chk("beq_bne", 8'(branch_ne), 8'd0);
        chk("beq_pcsrc", 8'(pc_source), 8'd1);
        chk("beq_aluop", 8'(alu_op), 8'd1);
        tick(); chk("beq_done", 8'(state), 8'd0);

        // bne
        ir_op = 6'b000101;
        tick(); tick();
        chk("bne_state", 8'(state), 8'd10);
        chk("bne_bne", 8'(branch_ne), 8'd1);
        tick(); chk("bne_done", 8'(state), 8'd0);

        // jal
        ir_op = 6'b000011;
        tick(); tick();
        chk("jal_state", 8'(state), 8'd11);
        chk("jal_pcw", 8'(pc_write), 8'd1);
        chk("jal_pcsrc", 8'(pc_source), 8'd2);
        chk("jal_regw", 8'(reg_write), 8'd1);
        chk("jal_dst", 8'(reg_dst), 8'd2);
        chk("jal_m2r", 8'(mem_to_reg), 8'd2);
        tick(); chk("jal_done", 8'(state), 8'd0);

        // andi
        ir_op = 6'b001100;
        tick(); tick();
        chk("andi_state", 8'(state), 8'd8);
        chk("andi_ext", 8'(ext_op), 8'd0);
        chk("andi_aluop", 8'(alu_op), 8'd3);
        tick(); chk("andi_wbi_state", 8'(state), 8'd9);
        chk("andi_wbi_regw", 8'(reg_write), 8'd1);
        chk("andi_wbi_dst", 8'(reg_dst), 8'd0);
        tick(); chk("andi_done", 8'(state), 8'd0);

        // slti: signed immediate, slt op
        ir_op = 6'b001010;
        tick(); tick();
        chk("slti_ext", 8'(ext_op), 8'd1);
        chk("slti_aluop", 8'(alu_op), 8'd5);
        tick(); tick(); chk("slti_done", 8'(state), 8'd0);

        // R-type
        ir_op = 6'b000000;
        tick(); tick();
        chk("r_state", 8'(state), 8'd6);
        chk("r_aluop", 8'(alu_op), 8'd2);
        tick(); chk("r_wbr_state", 8'(state), 8'd7);
        chk("r_wbr_dst", 8'(reg_dst), 8'd1);
        chk("r_wbr_regw", 8'(reg_write), 8'd1);
        tick(); chk("r_done", 8'(state), 8'd0);

        // Illegal opcode: 0,1,12,0 with a single illegal_op pulse
        ir_op = 6'b111111;
        chk("ill_if_pulse", 8'(illegal_op), 8'd0);
        tick(); chk("ill_id_pulse", 8'(illegal_op), 8'd0);
        tick(); chk("ill_state", 8'(state), 8'd12);
        chk("ill_pulse", 8'(illegal_op), 8'd1);
        tick(); chk("ill_done", 8'(state), 8'd0);
        chk("ill_after_pulse", 8'(illegal_op), 8'd0);

        // sw stalled in MWR, then reset mid-state
        ir_op = 6'b101011;
        tick(); tick();
        chk("sw_madr_state", 8'(state), 8'd2);
        mem_ready = 1'b0;
        tick(); chk("sw_mwr_state", 8'(state), 8'd5);
        chk("sw_mwr_memw", 8'(mem_write), 8'd1);
        chk("sw_mwr_iord", 8'(iord), 8'd1);
        tick(); chk("sw_hold_state", 8'(state), 8'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("sw_rst_memw", 8'(mem_write), 8'd0);
        chk("sw_rst_state", 8'(state), 8'd0);
        chk("sw_rst_memr", 8'(mem_read), 8'd0);
        tick(); chk("sw_rst_hold", 8'(state), 8'd0);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("post_rst_memr", 8'(mem_read), 8'd1);
        chk("post_rst_state", 8'(state), 8'd0);
        tick(); chk("post_rst_id", 8'(state), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl_fsm.md
Name: mcpu_ctrl_fsm

Overview:
Multi-cycle MIPS control unit. Sequences the datapath registers (PC, IR, MDR, A, B, ALUOut, each a CE-gated 32-bit register) and the register file, muxes and memory through fetch/decode/execute/memory/writeback states. Sits beside the datapath in MultiCycleCPU and drives every CE and mux select. Supports R-type, lw, sw, beq, bne, j, jal, addi, andi, ori and slti, and stalls on a memory ready handshake.

Parameters:
USE_MEM_READY, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
ir_op  in  6  IR[31:26], stable from ID onward
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC CE, unconditional
pc_write_cond  out  1  PC CE if the branch condition holds
branch_ne  out  1  1 = condition is !zero (bne); 0 = zero (beq)
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR CE
mdr_write  out  1  MDR CE
reg_write  out  1  register file write enable
reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = ext(imm), 11 = signext(imm)<<2
ext_op  out  1  1 = sign-extend, 0 = zero-extend
alu_op  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state  out  4  current state, for debug

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are combinational from the state, with mem_ready gating only where stated. Any output not listed for a state is 0.
- Reset (rst = 0): state goes to IF immediately, asynchronously. While reset is held, all write enables and strobes are forced to 0, and the other outputs take their IF values. Reset during any state, including a stalled memory access, aborts that state with no further strobes.
- IF (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00. ir_write=mem_ready and pc_write=mem_ready. Stays in IF while mem_ready=0; goes to ID when mem_ready=1.
- ID (1): alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=add (loads the branch target into ALUOut). Next state by ir_op:
  - 000000 -> EX_R
  - 100011 or 101011 -> MADR
  - 000100 or 000101 -> BR
  - 000010 or 000011 -> JMP
  - 001000, 001100, 001101 or 001010 -> EX_I
  - any other opcode -> ILL
- MADR (2): alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=add. Goes to MRD for lw, MWR for sw.
- MRD (3): mem_read=1, iord=1, mdr_write=mem_ready. Stays until mem_ready=1, then goes to WBM.
- WBM (4): reg_write=1, reg_dst=00, mem_to_reg=01. Goes to IF.
- MWR (5): mem_write=1, iord=1. Holds until mem_ready=1, then goes to IF.
- EX_R (6): alu_src_a=1, alu_src_b=00, alu_op=funct. Goes to WBR.
- WBR (7): reg_write=1, reg_dst=01, mem_to_reg=00. Goes to IF.
- EX_I (8): alu_src_a=1, alu_src_b=10. ext_op=0 for andi/ori, 1 otherwise. alu_op is add for addi, and for andi, or for ori, slt for slti. Goes to WBI.
- WBI (9): reg_write=1, reg_dst=00, mem_to_reg=00. Goes to IF.
- BR (10): alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_source=01. branch_ne=1 when ir_op=000101. Goes to IF.
- JMP (11): pc_write=1, pc_source=10. For jal, also reg_write=1, reg_dst=10, mem_to_reg=10; PC already holds PC+4 from IF. Goes to IF.
- ILL (12): illegal_op=1. Goes to IF.
- Encodings 13-15 go to IF with all outputs 0.
- Latency in cycles with zero-wait memory: R=4, lw=5, sw=4, beq/bne=3, j/jal=3, I-type=4, illegal=3. Each mem_ready=0 cycle in IF, MRD or MWR adds one cycle.

Decomposition:
- Package mcpu_ctrl_pkg holds:
  - opcode constants
  - state encodings
  - alu_op codes
  - reg_dst, mem_to_reg, alu_src_b and pc_source select constants
- Sub-module mcpu_ctrl_decode: purely combinational mapping from (state, ir_op, mem_ready) to the control word.
- mcpu_ctrl_fsm holds the state register and the next-state logic.

Test Plan:
- lw (ir_op=100011), mem_ready=1: states 0,1,2,3,4,0; mdr_write=1 in state 3; reg_write=1 with mem_to_reg=01 in state 4; 5 cycles total.
- IF stall (mem_ready=0 for 3 cycles, then 1): state stays 0 for 4 cycles; pc_write and ir_write are 0 for 3 cycles, then 1 for one cycle; then state 1.
- beq vs bne: ir_op=000100 gives state 10 with pc_write_cond=1, branch_ne=0, pc_source=01; ir_op=000101 gives branch_ne=1.
- jal (000011): state 11 with pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; then IF.
- andi (001100): state 8 with ext_op=0, alu_op=011; then state 9 with reg_write=1, reg_dst=00. Illegal opcode 111111: illegal_op=1 for exactly one cycle; state sequence 0,1,12,0.
- sw with mem_ready=0 in MWR, rst pulled low mid-state: mem_write drops to 0 in the same cycle and state=0. After rst goes high, the first fetch starts with mem_read=1.
